// File: rtl/i2c_pkg.sv
// Shared I2C constants and target state encoding.
// Imported by both the target and the initiator.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_LEN = 7;
    localparam int unsigned I2C_DAT_LEN  = 8;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX,
        ST_ACK_RX,
        ST_TX,
        ST_ACK_TX,
        ST_IGNORE
    } i2c_tgt_st_e;

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins plus fabric byte handshake of the I2C target.
// slave = the target side, master = whoever drives it.
interface i2c_target_if;
    import i2c_pkg::*;

    logic                   scl;
    logic                   sda_in;
    logic                   sda_oe;
    logic                   rx_valid;
    logic [I2C_DAT_LEN-1:0] rx_data;
    logic [I2C_DAT_LEN-1:0] tx_data;
    logic                   tx_load;
    logic                   busy;

    modport slave (
        input  scl,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output rx_valid,
        output rx_data,
        output tx_load,
        output busy
    );

    modport master (
        output scl,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  rx_valid,
        input  rx_data,
        input  tx_load,
        input  busy
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall detect on the synced value.
// Resets to the idle bus level so no false edge follows reset.
module i2c_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: oversampled SCL/SDA, open-drain SDA,
// written bytes out to fabric, read bytes served from fabric.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_LEN-1:0] OWN_ADDR = 7'h42,
    parameter int unsigned             DAT_LEN  = I2C_DAT_LEN
) (
    input logic         clk,
    input logic         rst_n,
    i2c_target_if.slave bus
);

    localparam logic [2:0] CNT_LAST = 3'(DAT_LEN - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_tgt_st_e        st_q, st_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [DAT_LEN-1:0] sh_q, sh_d;
    logic [DAT_LEN-1:0] samp;
    logic               ph_q, ph_d;
    logic               rw_q, rw_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               rxv_q, rxv_d;
    logic [DAT_LEN-1:0] rxd_q, rxd_d;
    logic               txl_q, txl_d;

    i2c_sync_edge #(.RST_VAL(1'b1)) u_scl (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.scl),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sync_edge #(.RST_VAL(1'b1)) u_sda (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.sda_in),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign samp      = {sh_q[DAT_LEN-2:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            sh_q   <= '0;
            ph_q   <= 1'b0;
            rw_q   <= I2C_WRITE;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
            rxv_q  <= 1'b0;
            rxd_q  <= '0;
            txl_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            ph_q   <= ph_d;
            rw_q   <= rw_d;
            oe_q   <= oe_d;
            busy_q <= busy_d;
            rxv_q  <= rxv_d;
            rxd_q  <= rxd_d;
            txl_q  <= txl_d;
        end
    end

    // ph_q marks the second half of an ACK slot (ACK driven / ACK seen).
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        ph_d   = ph_q;
        rw_d   = rw_q;
        oe_d   = oe_q;
        busy_d = busy_q;
        rxv_d  = 1'b0;
        rxd_d  = rxd_q;
        txl_d  = 1'b0;

        if (start_det) begin
            st_d  = ST_ADDR;
            cnt_d = '0;
            ph_d  = 1'b0;
            oe_d  = 1'b0;
        end else if (stop_det) begin
            st_d   = ST_IDLE;
            cnt_d  = '0;
            ph_d   = 1'b0;
            oe_d   = 1'b0;
            busy_d = 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = samp;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == CNT_LAST) begin
                            if (samp[DAT_LEN-1:1] == OWN_ADDR) begin
                                busy_d = 1'b1;
                                rw_d   = samp[0];
                                st_d   = ST_ACK_ADDR;
                            end else begin
                                busy_d = 1'b0;
                                st_d   = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d = 1'b1;
                            ph_d = 1'b1;
                        end else begin
                            ph_d  = 1'b0;
                            cnt_d = '0;
                            if (rw_q == I2C_READ) begin
                                st_d  = ST_TX;
                                sh_d  = bus.tx_data;
                                txl_d = 1'b1;
                                oe_d  = ~bus.tx_data[DAT_LEN-1];
                            end else begin
                                st_d = ST_RX;
                                oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        sh_d  = samp;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == CNT_LAST) begin
                            st_d = ST_ACK_RX;
                        end
                    end
                end
                ST_ACK_RX: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d  = 1'b1;
                            ph_d  = 1'b1;
                            rxd_d = sh_q;
                            rxv_d = 1'b1;
                        end else begin
                            oe_d = 1'b0;
                            ph_d = 1'b0;
                            st_d = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (cnt_q == CNT_LAST) begin
                            oe_d  = 1'b0;
                            cnt_d = '0;
                            st_d  = ST_ACK_TX;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            sh_d  = {sh_q[DAT_LEN-2:0], 1'b0};
                            oe_d  = ~sh_q[DAT_LEN-2];
                        end
                    end
                end
                ST_ACK_TX: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            st_d = ST_IGNORE;
                        end else begin
                            ph_d = 1'b1;
                        end
                    end else if (scl_fall && ph_q) begin
                        ph_d  = 1'b0;
                        cnt_d = '0;
                        sh_d  = bus.tx_data;
                        txl_d = 1'b1;
                        oe_d  = ~bus.tx_data[DAT_LEN-1];
                        st_d  = ST_TX;
                    end
                end
                ST_IGNORE: ;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    assign bus.sda_oe   = oe_q;
    assign bus.busy     = busy_q;
    assign bus.rx_valid = rxv_q;
    assign bus.rx_data  = rxd_q;
    assign bus.tx_load  = txl_q;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave) for the 100 kHz bus driven by the team's I2C initiator; the on-board test/debug path uses it for loopback.
- Oversamples SCL/SDA on a fast system clock and detects START, STOP and repeated START.
- Matches its 7-bit address, acknowledges, and then either delivers written bytes to fabric or serves read bytes from fabric. Drives SDA open-drain.

Parameters:
- OWN_ADDR, 7'h42, 7-bit bus address this target responds to.
- DAT_LEN, 8, data byte width; must stay 8.

Ports:
- clk  input  1  system clock; at least 20x SCL frequency (e.g. 10 MHz for 100 kHz).
- rst_n  input  1  reset, asynchronous, active-low.
- scl  input  1  bus SCL, asynchronous to clk.
- sda_in  input  1  bus SDA sense, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low; 0 = release (bus pad is 'z').
- rx_valid  output  1  one-clk pulse: rx_data holds a newly written byte.
- rx_data  output  8  last byte written by the initiator.
- tx_data  input  8  byte to return on the next read byte.
- tx_load  output  1  one-clk pulse: tx_data captured; fabric may update it.
- busy  output  1  1 from address match until STOP or non-matching repeated START.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: sda_oe=0, rx_valid=0, rx_data=0, tx_load=0, busy=0, state IDLE.
- Input sync: scl and sda_in each pass through a 2-flop synchronizer. Edges are taken from the synced value vs its 1-clk delayed copy.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- Bit sampling: on synced SCL rising edge, MSB first.
- Drive changes: sda_oe changes only on the synced SCL falling edge, except on STOP or reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W).
  - ACK_ADDR: on match drive ACK; on mismatch go to IGNORE.
  - RX: shift 8 data bits.
  - ACK_RX: drive ACK.
  - TX: drive 8 data bits.
  - ACK_TX: release SDA; sample the initiator's ACK/NACK.
  - IGNORE: wait for START or STOP.
- Address phase:
  - After the 8th rising edge, compare bits[7:1] with OWN_ADDR.
  - Match: busy=1; on the following SCL fall set sda_oe=1 for the 9th clock; latch R/W (1 = read).
  - Mismatch: sda_oe stays 0; go to IGNORE.
- Write (R/W=0):
  - After the 8th data bit, rx_data updates and rx_valid pulses for exactly 1 clk, both on the SCL falling edge that begins the ACK slot.
  - sda_oe=1 for the ACK clock, released on the next SCL fall; return to RX.
  - Every byte is ACKed; there is no flow control or clock stretching.
- Read (R/W=1):
  - On the SCL fall ending the address ACK, capture tx_data into the shift register and pulse tx_load.
  - sda_oe = NOT(current bit); advance one bit per SCL fall.
  - After 8 bits, release SDA in ACK_TX and sample on the 9th rising edge.
  - ACK (0): reload tx_data and pulse tx_load on the next fall; stay in TX.
  - NACK (1): go to IGNORE (SDA released) until STOP or START.
- Repeated START in any state: release sda_oe; go to ADDR with bit counter cleared. busy stays 1 until the new address is resolved.
- STOP in any state: sda_oe=0, busy=0, go to IDLE. A partial byte is discarded with no rx_valid pulse.
- Simultaneous START/STOP detection and a data edge cannot occur: START/STOP require SCL high. A START/STOP detection takes priority over any pending bit action in the same clk.
- Bit counter: 0..7, wraps to 0 at each byte/ACK boundary.

Decomposition:
- Shared package i2c_pkg holds:
  - I2C_ADDR_LEN=7 and I2C_DAT_LEN=8.
  - I2C_READ=1 and I2C_WRITE=0.
  - The target state enum.
- The initiator uses the same constants.
- One sub-module, i2c_sync_edge, covers the 2-flop synchronizer plus rise/fall detect. It is instantiated for scl and for sda_in.

Test Plan:
- Write 7'h42 + W, byte 8'hA5, STOP -> ACK on address and data clocks; one rx_valid pulse with rx_data=8'hA5; busy returns to 0 after STOP.
- Read 7'h42 + R with tx_data=8'h3C, initiator NACKs -> bus shows 0011_1100 MSB first; one tx_load; sda_oe=0 through STOP.
- Address 7'h43 + W, byte 8'hFF -> sda_oe never asserts; no rx_valid; busy stays 0.
- Read two bytes with ACK then NACK, fabric changing tx_data 8'h01->8'h02 after the first tx_load -> bus returns 8'h01 then 8'h02; two tx_load pulses.
- Write 8'h11, then repeated START with 7'h42 + R -> rx_valid for 8'h11; address ACK; read proceeds without an intervening STOP.
- STOP after 4 data bits, and separately rst_n low mid-TX -> no rx_valid; sda_oe=0 immediately on reset; state IDLE; next full transaction succeeds.
